clock_set_controller: RTL

- Sequences the time-set procedure for the digital clock timekeeper: debounces the four pushbuttons, walks the user through hour-upper, hour-lower, minute-upper and minute-lower digit entry from the switches, and range-checks each digit.
- Loads the validated time into the timekeeper with a single-cycle load pulse.
- Drives setup_mode, loc and blink to the display driver.
- Sits between board I/O (PB, DSW), the timekeeper counters and the display driver.

---
 rtl/clock_set_controller.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
// Time-set sequencer for the digital clock. It debounces the four pushbuttons
// and walks the user through hour-upper, hour-lower, minute-upper and
// minute-lower digit entry from the DSW switches, clamping each digit to its
// legal range. A validated time goes to the timekeeper with a one-cycle
// time_load strobe.
//
// Ports
//   clk         in   system clock (50 MHz)
//   rst_n       in   asynchronous active-low reset
//   pb_n[3:0]   in   raw buttons, active-low: 0 NEXT, 1 BACK, 2 CANCEL, 3 ENTER
//   dsw[3:0]    in   digit value switches
//   sec_tick    in   one-cycle pulse per second
//   cur_*[3:0]  in   running time from the timekeeper (BCD)
//   set_*[3:0]  out  shadow time being edited (BCD)
//   time_load   out  one-cycle load strobe to the timekeeper
//   setup_mode  out  high while a SET_* or COMMIT state is active
//   loc[1:0]    out  selected digit: 0 HU, 1 HL, 2 MU, 3 ML
//   blink       out  blank phase for the selected digit
//
// Optional feature macro: SET_TIMEOUT_EN
//   Defined: setup aborts, like CANCEL, after TIMEOUT_SEC seconds without a
//   button press, as long as a valid time has been loaded before.
// -----------------------------------------------------------------------------
module clock_set_controller #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TIMEOUT_SEC  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pb_n,
  input  logic [3:0] dsw,
  input  logic       sec_tick,
  input  logic [3:0] cur_hu,
  input  logic [3:0] cur_hl,
  input  logic [3:0] cur_mu,
  input  logic [3:0] cur_ml,
  output logic [3:0] set_hu,
  output logic [3:0] set_hl,
  output logic [3:0] set_mu,
  output logic [3:0] set_ml,
  output logic       time_load,
  output logic       setup_mode,
  output logic [1:0] loc,
  output logic       blink
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_HU = 3'd1,
    ST_SET_HL = 3'd2,
    ST_SET_MU = 3'd3,
    ST_SET_ML = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  // Saturate a digit to its upper limit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] lim);
    if (v > lim) return lim;
    else         return v;
  endfunction

  logic [3:0]    sync1_q, sync2_q, deb_q, deb_d, deb_dly_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    press_s;
  logic          ev_next_s, ev_back_s, ev_enter_s, cancel_s, timeout_s, in_set_s;
  state_t        state_q, state_d;
  logic [3:0]    set_hu_q, set_hl_q, set_mu_q, set_ml_q, hu_new_s, hl_lim_s;
  logic [1:0]    loc_q;
  logic          blink_q, time_load_q, setup_mode_q, time_valid_q;

  // Button synchronizers, debounced levels and edge-detect delay (released = 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      deb_q     <= 4'hF;
      deb_dly_q <= 4'hF;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= pb_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Debounce: count consecutive samples that disagree with the debounced level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
        cnt_d[i] = '0;
        deb_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // A press event is the debounced 1->0 edge, so a held button fires once.
  assign press_s    = deb_dly_q & ~deb_q;
  assign ev_next_s  = press_s[0];
  assign ev_back_s  = press_s[1];
  assign ev_enter_s = press_s[3];
  assign in_set_s   = (state_q == ST_SET_HU) || (state_q == ST_SET_HL) ||
                      (state_q == ST_SET_MU) || (state_q == ST_SET_ML);

`ifdef SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  logic [TW-1:0] to_cnt_q;

  assign timeout_s = (to_cnt_q == TW'(TIMEOUT_SEC));

  // Inactivity seconds counter. Entry to SET_HU always comes from a press, so
  // clearing on any press also covers the entry case. Saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               to_cnt_q <= '0;
    else if (|press_s)                        to_cnt_q <= '0;
    else if (in_set_s && sec_tick && !timeout_s) to_cnt_q <= to_cnt_q + TW'(1);
    else                                      to_cnt_q <= to_cnt_q;
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Abort is only honoured once a valid time exists; before that the user must commit.
  assign cancel_s = (press_s[2] | timeout_s) & time_valid_q;
  assign hu_new_s = clamp_digit(dsw, 4'd2);
  assign hl_lim_s = (set_hu_q < 4'd2) ? 4'd9 : 4'd3;

  // Next-state selection; CANCEL outranks NEXT, which outranks BACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (ev_enter_s) state_d = ST_SET_HU; else state_d = ST_RUN;
      ST_SET_HU: if (cancel_s) state_d = ST_RUN; else if (ev_next_s) state_d = ST_SET_HL;
                 else state_d = ST_SET_HU;
      ST_SET_HL: if (cancel_s) state_d = ST_RUN; else if (ev_next_s) state_d = ST_SET_MU;
                 else if (ev_back_s) state_d = ST_SET_HU; else state_d = ST_SET_HL;
      ST_SET_MU: if (cancel_s) state_d = ST_RUN; else if (ev_next_s) state_d = ST_SET_ML;
                 else if (ev_back_s) state_d = ST_SET_HL; else state_d = ST_SET_MU;
      ST_SET_ML: if (cancel_s) state_d = ST_RUN; else if (ev_next_s) state_d = ST_COMMIT;
                 else if (ev_back_s) state_d = ST_SET_MU; else state_d = ST_SET_ML;
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_SET_HU;
    endcase
  end

  // FSM state, registered outputs and shadow digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SET_HU;
      set_hu_q     <= 4'd0;
      set_hl_q     <= 4'd0;
      set_mu_q     <= 4'd0;
      set_ml_q     <= 4'd0;
      loc_q        <= 2'd0;
      blink_q      <= 1'b0;
      time_load_q  <= 1'b0;
      setup_mode_q <= 1'b1;
      time_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_load_q  <= (state_d == ST_COMMIT);
      setup_mode_q <= (state_d != ST_RUN);
      if (state_q == ST_COMMIT) time_valid_q <= 1'b1;
      else                      time_valid_q <= time_valid_q;

      if (state_d != state_q)        blink_q <= 1'b0;
      else if (in_set_s && sec_tick) blink_q <= ~blink_q;
      else                           blink_q <= blink_q;

      case (state_d)
        ST_SET_HU: loc_q <= 2'd0;
        ST_SET_HL: loc_q <= 2'd1;
        ST_SET_MU: loc_q <= 2'd2;
        ST_SET_ML: loc_q <= 2'd3;
        default:   loc_q <= loc_q;
      endcase

      case (state_q)
        ST_RUN: begin
          if (ev_enter_s) begin
            set_hu_q <= cur_hu;
            set_hl_q <= cur_hl;
            set_mu_q <= cur_mu;
            set_ml_q <= cur_ml;
          end
        end
        ST_SET_HU: begin
          set_hu_q <= hu_new_s;
          // Leaving with hour 2x: pull an out-of-range lower hour down to 23.
          if ((state_d != ST_SET_HU) && (hu_new_s == 4'd2) && (set_hl_q > 4'd3))
            set_hl_q <= 4'd3;
        end
        ST_SET_HL: set_hl_q <= clamp_digit(dsw, hl_lim_s);
        ST_SET_MU: set_mu_q <= clamp_digit(dsw, 4'd5);
        ST_SET_ML: set_ml_q <= clamp_digit(dsw, 4'd9);
        default: begin
          set_hu_q <= set_hu_q;
        end
      endcase
    end
  end

  assign set_hu     = set_hu_q;
  assign set_hl     = set_hl_q;
  assign set_mu     = set_mu_q;
  assign set_ml     = set_ml_q;
  assign time_load  = time_load_q;
  assign setup_mode = setup_mode_q;
  assign loc        = loc_q;
  assign blink      = blink_q;

endmodule
